// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 initiator that turns a valid/ready command into SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic              done_s;
  logic              timeout_hit_s;
  logic              cmd_ready_r;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              unused_s;

  // Byte-lane bits of the command address never reach the bus.
  assign unused_s = ^cmd_addr[1:0];

  assign accept_s = (state_r == IDLE) && cmd_valid && cmd_ready_r;
  assign done_s   = (state_r == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_r;

  // Wait-state counter: zeroed in SETUP so it starts clean on ACCESS entry.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == SETUP) begin
      wait_cnt_r <= 16'd0;
    end else if ((state_r == ACCESS) && !PREADY) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // PREADY has priority: the abort only fires on a cycle that is still a wait state.
  assign timeout_hit_s = (state_r == ACCESS) && !PREADY && (wait_cnt_r == WAIT_LAST);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign timeout_hit_s = 1'b0;
`endif

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = SETUP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETUP: begin
        state_nx_s = ACCESS;
      end
      ACCESS: begin
        if (done_s || timeout_hit_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and handshake/bus strobes, all registered from the next state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= (state_nx_s == IDLE);
      psel_r      <= (state_nx_s == SETUP) || (state_nx_s == ACCESS);
      penable_r   <= (state_nx_s == ACCESS);
      rsp_valid_r <= (state_nx_s == RESP);
    end
  end

  // Command capture: address, direction and write data hold until the next accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_r  <= {ADDR_W{1'b0}};
      pwrite_r <= 1'b0;
      pwdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      paddr_r  <= {cmd_addr[ADDR_W-1:2], 2'b00};
      pwrite_r <= cmd_write;
      pwdata_r <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
    end else begin
      paddr_r  <= paddr_r;
      pwrite_r <= pwrite_r;
      pwdata_r <= pwdata_r;
    end
  end

  // Response capture on the completion edge (or on a timeout abort).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (done_s) begin
      rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : PRDATA;
      rsp_err_r   <= PSLVERR;
    end else if (timeout_hit_s) begin
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b1;
    end else begin
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table driven through a scripted APB slave,
// responses checked against a scoreboard queue, plus reset corner sequences.
module tb_apb_master_bridge;

  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slv_wait;
    logic        slv_done;
    int          hold;
    logic [11:0] exp_paddr;
    logic [31:0] exp_pwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_master_bridge #(
    .ADDR_W(12),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                              input int w, input logic [31:0] prd, input logic sw, input logic sd,
                              input int h, input logic [11:0] ea, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic ee);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.waits = w; v.prdata = prd;
    v.slv_wait = sw; v.slv_done = sd; v.hold = h; v.exp_paddr = ea;
    v.exp_pwdata = ewd; v.exp_rdata = erd; v.exp_err = ee;
    return v;
  endfunction

  task automatic take_rsp(input int hold);
    rsp_t exp;
    int   g;
    g = 0;
    while (!rsp_valid && g < 50) begin
      step();
      g++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      exp.rdata = 32'd0;
      exp.err   = 1'b0;
    end else begin
      exp = sb.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, exp.rdata);
      check("hold_rsp_err", 32'(rsp_err), 32'(exp.err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_psel", 32'(PSEL), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    check("rsp_rdata", rsp_rdata, exp.rdata);
    check("rsp_err", 32'(rsp_err), 32'(exp.err));
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    check("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_xfer(input vec_t v);
    int   guard;
    int   acc;
    bit   abort;
    bit   last;
    rsp_t r;
    abort = TO_EN && (v.waits >= TO);
    acc   = abort ? TO : v.waits + 1;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    r.rdata = v.exp_rdata;
    r.err   = v.exp_err;
    sb.push_back(r);
    step();
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    check("setup_psel", 32'(PSEL), 32'd1);
    check("setup_penable", 32'(PENABLE), 32'd0);
    check("setup_paddr", 32'(PADDR), 32'(v.exp_paddr));
    check("setup_pwrite", 32'(PWRITE), 32'(v.write));
    check("setup_pwdata", PWDATA, v.exp_pwdata);
    check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    for (int i = 0; i < acc; i++) begin
      check("access_psel", 32'(PSEL), 32'd1);
      check("access_penable", 32'(PENABLE), 32'd1);
      check("access_paddr", 32'(PADDR), 32'(v.exp_paddr));
      check("access_pwrite", 32'(PWRITE), 32'(v.write));
      check("access_pwdata", PWDATA, v.exp_pwdata);
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      last    = !abort && (i == v.waits);
      PREADY  = last;
      PSLVERR = last ? v.slv_done : v.slv_wait;
      PRDATA  = last ? v.prdata : $urandom;
      step();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    check("done_psel", 32'(PSEL), 32'd0);
    check("done_penable", 32'(PENABLE), 32'd0);
    check("done_rsp_valid", 32'(rsp_valid), 32'd1);
    check("resp_paddr_held", 32'(PADDR), 32'(v.exp_paddr));
    take_rsp(v.hold);
  endtask

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 12'h000;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // write/addr/wdata/waits/prdata/slv_wait/slv_done/hold -> paddr/pwdata/rdata/err
    vecs.push_back(mk(1'b1, 12'h004, 32'h0000_0001, 0, 32'hCAFE_0000, 1'b0, 1'b0, 0, 12'h004, 32'h0000_0001, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 12'h00C, 32'hFFFF_FFFF, 3, 32'h0000_4321, 1'b0, 1'b0, 0, 12'h00C, 32'h0, 32'h0000_4321, 1'b0));
    vecs.push_back(mk(1'b0, 12'h007, 32'h1111_1111, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 12'h004, 32'h0, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 12'h800, 32'h0, 1, 32'h8000_0001, 1'b0, 1'b0, 5, 12'h800, 32'h0, 32'h8000_0001, 1'b0));
    vecs.push_back(mk(1'b1, 12'h010, 32'h0000_A5A5, 1, 32'h0000_1234, 1'b0, 1'b1, 0, 12'h010, 32'h0000_A5A5, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 12'h020, 32'h5A5A_0F0F, 2, 32'h0, 1'b1, 1'b0, 0, 12'h020, 32'h5A5A_0F0F, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 12'hFFF, 32'h0, 3, 32'h0000_55AA, 1'b1, 1'b1, 0, 12'hFFC, 32'h0, 32'h0000_55AA, 1'b1));
`ifdef APB_MASTER_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 12'h100, 32'h0, 10, 32'h0000_0777, 1'b0, 1'b0, 0, 12'h100, 32'h0, 32'h0, 1'b1));
`endif

    repeat (2) @(posedge PCLK);
    #1;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    PRESETn = 1'b1;
    #1;
    check("release_cmd_ready_low", 32'(cmd_ready), 32'd0);
    step();
    check("release_cmd_ready_up", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      do_xfer(vecs[i]);
    end

    // Reset in the middle of ACCESS: no response may survive it.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h0AC;
    cmd_wdata = 32'h1357_9BDF;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("midrst_in_access", 32'(PENABLE), 32'd1);
    #3;
    PRESETn = 1'b0;
    #1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_paddr", 32'(PADDR), 32'd0);
    check("midrst_pwdata", PWDATA, 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    PRESETn = 1'b1;
    step();
    check("midrst_release_ready", 32'(cmd_ready), 32'd1);
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_stale_rsp", 32'(rsp_valid), 32'd0);
      check("midrst_idle_psel", 32'(PSEL), 32'd0);
      step();
    end
    PREADY = 1'b0;

    do_xfer(vecs[0]);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
